intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
Interrupt controller feeding the interrupt vector table stage. It captures rising edges on 8 external interrupt lines, holds them as pending, and applies a CPU-written enable mask. It arbitrates by fixed priority (bit 0 highest) and presents a stable one-hot intr_selec to the vector lookup. A req/ack/ret handshake with the CPU control unit brackets each service; there is no nesting.

Parameters:
N_INTR, 8, number of interrupt lines; fixed at 8 to match the 8-bit vector selector
SYNC_STAGES, 2, flip-flop synchronizer depth on intr_in; legal values 1..3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
intr_in  input  8  raw interrupt lines, asynchronous, level
mask_we  input  1  mask register write strobe
mask_in  input  8  new mask value; bit=1 enables the line
intr_ack  input  1  CPU accepted the request; one-cycle pulse
intr_ret  input  1  CPU executed return-from-interrupt; one-cycle pulse
intr_req  output  1  interrupt request to the CPU
intr_selec  output  8  one-hot selected line, to the vector lookup; 0 when idle
in_service  output  1  handler is executing
pending_out  output  8  pending register, for status read

Behaviour:
- Reset (async, immediate, also mid-operation): sync flops=0, edge-history=0, pending=0, mask=0 (all disabled), state=IDLE, intr_req=0, intr_selec=0, in_service=0.
- Sync/edge: intr_in passes through SYNC_STAGES flops; a registered previous value detects 0->1. A rising edge sets pending[i] on the next clock. The bit is set even if masked. A high level first sampled at edge k sets pending at edge k+SYNC_STAGES. A held high level does not re-trigger.
- Mask: on mask_we, mask<=mask_in at the clock edge. Arbitration in that same cycle uses the old mask.
- eligible = pending & mask. winner = lowest set bit of eligible.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: intr_selec=0, intr_req=0. If eligible!=0: intr_selec<=onehot(winner), intr_req<=1, go REQ.
  - REQ: intr_selec is frozen; a higher-priority arrival does not preempt it. A mask write that disables the selected bit does not withdraw the request. On intr_ack: pending[sel] cleared, intr_req<=0, in_service<=1, go SERVICE.
  - SERVICE: intr_selec held stable for the vector lookup and return logic. On intr_ret: intr_selec<=0, in_service<=0, go IDLE. A still-eligible request raises intr_req on the following edge. Minimum gap: 1 cycle with intr_req=0.
- Clear vs new edge on the same bit in the same cycle (ack clears the bit, new edge sets it): set wins, and the bit stays pending.
- Ignored inputs: intr_ack outside REQ; intr_ret outside SERVICE; intr_ack and intr_ret together in REQ, where ack is taken and ret is dropped.
- intr_selec is always 0 or exactly one-hot; never X. The downstream lookup's default branch is never exercised.
- pending_out = pending register, no extra latency.
- All outputs are registered.

Test Plan:
- Reset, mask_in=8'hFF written; intr_in=8'h04 rising at cycle 0 -> pending_out=8'h04 after 2 clocks; next clock intr_req=1, intr_selec=8'h04; ack -> pending_out=0, in_service=1; ret -> intr_selec=0, intr_req stays 0.
- Priority: intr_in=8'h90 rises together, mask=8'hFF -> first service intr_selec=8'h10; after ret, 2nd intr_req with intr_selec=8'h80.
- Masking: mask=8'h00, intr_in=8'h01 edge -> pending_out=8'h01, intr_req stays 0 for 20 cycles. Write mask=8'h01 -> intr_req=1 one cycle after the write edge, intr_selec=8'h01.
- No preemption: in SERVICE with selec=8'h20, bit0 edge arrives -> intr_selec holds 8'h20 until ret, then intr_req with 8'h01 one clock later.
- Collision: bit3 edge lands in the same cycle as intr_ack for selec=8'h08 -> pending_out[3]=1 after the clock; re-requested after ret.
- Reset mid-SERVICE with pending=8'h06 -> all outputs 0 immediately, before the next clk edge. After release with mask=0, no request is made.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl -- 8-line interrupt controller feeding the vector table stage.
//
// Captures rising edges on intr_in and holds them as pending. Pending bits
// are set whether or not the line is masked. A fixed-priority arbiter (bit 0
// highest) picks among pending & mask. A req/ack/ret handshake with the CPU
// brackets each service, and nested interrupts are not supported.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   intr_in     raw interrupt lines (asynchronous levels)
//   mask_we     mask register write strobe
//   mask_in     new mask value, bit=1 enables the line
//   intr_ack    CPU accepted the request (one-cycle pulse)
//   intr_ret    CPU executed return-from-interrupt (one-cycle pulse)
//   intr_req    interrupt request to the CPU (registered)
//   intr_selec  one-hot selected line, 0 when idle (registered)
//   in_service  handler is executing (registered)
//   pending_out pending register, for status read
module intr_ctrl #(
  parameter int N_INTR      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr_in,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_in,
  input  logic              intr_ack,
  input  logic              intr_ret,
  output logic              intr_req,
  output logic [N_INTR-1:0] intr_selec,
  output logic              in_service,
  output logic [N_INTR-1:0] pending_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t                             state;
  logic [SYNC_STAGES-1:0][N_INTR-1:0] sync_q;
  logic [N_INTR-1:0]                  prev_q;
  logic [N_INTR-1:0]                  pending_q;
  logic [N_INTR-1:0]                  mask_q;

  logic [N_INTR-1:0] rise;
  logic [N_INTR-1:0] eligible;
  logic [N_INTR-1:0] winner;
  logic [N_INTR-1:0] clr;

  always_comb begin
    rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    eligible = pending_q & mask_q;
    // Isolate the lowest set bit: bit 0 has the highest priority.
    winner   = eligible & (~eligible + N_INTR'(1));
    clr      = '0;
    if (state == REQ && intr_ack) begin
      clr = intr_selec;
    end
  end

  assign pending_out = pending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      state      <= IDLE;
      intr_req   <= 1'b0;
      intr_selec <= '0;
      in_service <= 1'b0;
    end else begin
      sync_q[0] <= intr_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];

      // A new edge on the bit being acknowledged wins over the clear, so
      // that arrival is not lost.
      pending_q <= (pending_q & ~clr) | rise;

      if (mask_we) begin
        mask_q <= mask_in;
      end

      case (state)
        IDLE: begin
          if (eligible != '0) begin
            intr_selec <= winner;
            intr_req   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // Selection is frozen here: neither a higher-priority arrival nor
          // a mask change withdraws the outstanding request.
          if (intr_ack) begin
            intr_req   <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (intr_ret) begin
            intr_selec <= '0;
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          intr_req   <= 1'b0;
          intr_selec <= '0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Testbench for intr_ctrl. Each step drives the inputs for one clock and
// queues the output state expected after that edge. The observed state is
// queued after the edge, and each scenario task drains and compares both
// queues. Packed state layout is {intr_req, intr_selec, in_service, pending_out}.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] intr_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       intr_ack;
  logic       intr_ret;
  logic       intr_req;
  logic [7:0] intr_selec;
  logic       in_service;
  logic [7:0] pending_out;

  typedef logic [17:0] st_t;

  st_t exp_q[$];
  st_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  localparam st_t IDL = 18'h0;

  intr_ctrl #(.N_INTR(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .intr_in    (intr_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .intr_ack   (intr_ack),
    .intr_ret   (intr_ret),
    .intr_req   (intr_req),
    .intr_selec (intr_selec),
    .in_service (in_service),
    .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  function automatic st_t pk(input logic req, input logic [7:0] sel,
                             input logic svc, input logic [7:0] pend);
    return {req, sel, svc, pend};
  endfunction

  function automatic st_t sample();
    return {intr_req, intr_selec, in_service, pending_out};
  endfunction

  // Drive one clock of stimulus, queue the expected post-edge state, then
  // capture the observed post-edge state.
  task automatic step(input logic [7:0] in, input logic ack, input logic ret,
                      input logic mwe, input logic [7:0] m, input st_t e);
    intr_in  = in;
    intr_ack = ack;
    intr_ret = ret;
    mask_we  = mwe;
    mask_in  = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(sample());
    intr_ack = 1'b0;
    intr_ret = 1'b0;
    mask_we  = 1'b0;
  endtask

  task automatic test_reset();
    st_t e, g;
    int  k = 0;
    intr_in = '0; mask_we = 0; mask_in = '0; intr_ack = 0; intr_ret = 0;
    reset = 1'b1;
    exp_q.push_back(IDL);
    repeat (3) @(posedge clk);
    #1;
    obs_q.push_back(sample());
    @(negedge clk);
    reset = 1'b0;
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_basic();
    st_t e, g;
    int  k = 0;
    step(8'h00, 0, 0, 1, 8'hFF, IDL);
    step(8'h04, 0, 0, 0, 8'h00, IDL);
    step(8'h04, 0, 0, 0, 8'h00, IDL);
    step(8'h04, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h04));
    step(8'h04, 0, 0, 0, 8'h00, pk(1, 8'h04, 0, 8'h04));
    step(8'h04, 0, 0, 0, 8'h00, pk(1, 8'h04, 0, 8'h04));
    step(8'h04, 1, 0, 0, 8'h00, pk(0, 8'h04, 1, 8'h00));
    step(8'h04, 0, 0, 0, 8'h00, pk(0, 8'h04, 1, 8'h00));
    step(8'h04, 0, 1, 0, 8'h00, IDL);
    step(8'h04, 0, 0, 0, 8'h00, IDL);
    step(8'h04, 0, 0, 0, 8'h00, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL basic[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_priority();
    st_t e, g;
    int  k = 0;
    repeat (3) step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h90, 0, 0, 0, 8'h00, IDL);
    step(8'h90, 0, 0, 0, 8'h00, IDL);
    step(8'h90, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h90));
    step(8'h90, 0, 0, 0, 8'h00, pk(1, 8'h10, 0, 8'h90));
    step(8'h90, 1, 0, 0, 8'h00, pk(0, 8'h10, 1, 8'h80));
    step(8'h90, 0, 1, 0, 8'h00, pk(0, 8'h00, 0, 8'h80));
    step(8'h90, 0, 0, 0, 8'h00, pk(1, 8'h80, 0, 8'h80));
    step(8'h90, 1, 0, 0, 8'h00, pk(0, 8'h80, 1, 8'h00));
    step(8'h90, 0, 1, 0, 8'h00, IDL);
    step(8'h90, 0, 0, 0, 8'h00, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL priority[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_mask();
    st_t e, g;
    int  k = 0;
    step(8'h00, 0, 0, 1, 8'h00, IDL);
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h01, 0, 0, 0, 8'h00, IDL);
    step(8'h01, 0, 0, 0, 8'h00, IDL);
    step(8'h01, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h01));
    repeat (20) step(8'h01, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h01));
    // Write edge: arbitration still sees the old mask.
    step(8'h01, 0, 0, 1, 8'h01, pk(0, 8'h00, 0, 8'h01));
    step(8'h01, 0, 0, 0, 8'h00, pk(1, 8'h01, 0, 8'h01));
    step(8'h01, 1, 0, 0, 8'h00, pk(0, 8'h01, 1, 8'h00));
    step(8'h01, 0, 1, 0, 8'h00, IDL);
    step(8'h01, 0, 0, 1, 8'hFF, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL mask[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_no_preempt();
    st_t e, g;
    int  k = 0;
    step(8'h00, 1, 1, 0, 8'h00, IDL);  // ack/ret in IDLE are ignored
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h20, 0, 0, 0, 8'h00, IDL);
    step(8'h20, 0, 0, 0, 8'h00, IDL);
    step(8'h20, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h20));
    step(8'h20, 0, 0, 0, 8'h00, pk(1, 8'h20, 0, 8'h20));
    // ret in REQ ignored; masking the selected bit keeps the request.
    step(8'h20, 0, 1, 1, 8'hDF, pk(1, 8'h20, 0, 8'h20));
    step(8'h20, 1, 0, 0, 8'h00, pk(0, 8'h20, 1, 8'h00));
    step(8'h21, 0, 0, 0, 8'h00, pk(0, 8'h20, 1, 8'h00));
    step(8'h21, 0, 0, 0, 8'h00, pk(0, 8'h20, 1, 8'h00));
    step(8'h21, 0, 0, 0, 8'h00, pk(0, 8'h20, 1, 8'h01));
    step(8'h21, 1, 0, 0, 8'h00, pk(0, 8'h20, 1, 8'h01));
    step(8'h21, 0, 1, 0, 8'h00, pk(0, 8'h00, 0, 8'h01));
    step(8'h21, 0, 0, 0, 8'h00, pk(1, 8'h01, 0, 8'h01));
    step(8'h21, 1, 1, 0, 8'h00, pk(0, 8'h01, 1, 8'h00));
    step(8'h21, 0, 0, 0, 8'h00, pk(0, 8'h01, 1, 8'h00));
    step(8'h21, 0, 1, 0, 8'h00, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL no_preempt[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_collision();
    st_t e, g;
    int  k = 0;
    step(8'h00, 0, 0, 1, 8'hFF, IDL);
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h08, 0, 0, 0, 8'h00, IDL);
    step(8'h08, 0, 0, 0, 8'h00, IDL);
    step(8'h08, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h08));
    step(8'h08, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h00, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h00, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h00, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h08, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h08, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    // Second edge on bit 3 lands on the ack edge: it stays pending.
    step(8'h08, 1, 0, 0, 8'h00, pk(0, 8'h08, 1, 8'h08));
    step(8'h08, 0, 1, 0, 8'h00, pk(0, 8'h00, 0, 8'h08));
    step(8'h08, 0, 0, 0, 8'h00, pk(1, 8'h08, 0, 8'h08));
    step(8'h08, 1, 0, 0, 8'h00, pk(0, 8'h08, 1, 8'h00));
    step(8'h08, 0, 1, 0, 8'h00, IDL);
    step(8'h08, 0, 0, 0, 8'h00, IDL);
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL collision[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_service();
    st_t e, g;
    int  k = 0;
    repeat (3) step(8'h00, 0, 0, 0, 8'h00, IDL);
    step(8'h07, 0, 0, 0, 8'h00, IDL);
    step(8'h07, 0, 0, 0, 8'h00, IDL);
    step(8'h07, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h07));
    step(8'h07, 0, 0, 0, 8'h00, pk(1, 8'h01, 0, 8'h07));
    step(8'h07, 1, 0, 0, 8'h00, pk(0, 8'h01, 1, 8'h06));
    step(8'h07, 0, 0, 0, 8'h00, pk(0, 8'h01, 1, 8'h06));
    // Assert reset between clock edges; outputs must clear at once.
    #2;
    reset = 1'b1;
    exp_q.push_back(IDL);
    #1;
    obs_q.push_back(sample());
    @(negedge clk);
    reset = 1'b0;
    // Sync chain restarts at 0, so the held level is a fresh edge, but the
    // mask is cleared and nothing is requested.
    step(8'h07, 0, 0, 0, 8'h00, IDL);
    step(8'h07, 0, 0, 0, 8'h00, IDL);
    step(8'h07, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h07));
    repeat (5) step(8'h07, 0, 0, 0, 8'h00, pk(0, 8'h00, 0, 8'h07));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got req=%b sel=%h svc=%b pend=%h, required req=%b sel=%h svc=%b pend=%h",
                 k, g[17], g[16:9], g[8], g[7:0], e[17], e[16:9], e[8], e[7:0]);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_no_preempt();
    test_collision();
    test_reset_mid_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
